// File: rtl/instr_fetch_unit.sv
// Program memory plus fetch stage: walks the stored program, assembles one- or
// two-byte instructions and presents them to the core over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_wdata,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              core_ready,
  output logic [7:0]        instr_out,
  output logic [7:0]        operand_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              busy,
  output logic              prog_err
);

  typedef enum logic [2:0] {IDLE, ADDR, OPC, OPND, HOLD} state_t;

  localparam logic [3:0] OP_JUMP = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_reg, state_next;
  logic [7:0]        mem [MEM_DEPTH];
  logic [7:0]        rdata_reg;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] fetch_ptr_reg;
  logic [7:0]        instr_reg;
  logic [7:0]        operand_reg;
  logic              err_reg;
  logic              handshake;

  function automatic logic is_two_byte(input logic [3:0] op);
    case (op)
      4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: is_two_byte = 1'b1;
      default:                            is_two_byte = 1'b0;
    endcase
  endfunction

  assign handshake = (state_reg == HOLD) && core_ready;

  // Host writes only land while idle, so the single read port never races a write.
  always_ff @(posedge clk) begin
    if (prog_we && (state_reg == IDLE))
      mem[prog_addr] <= prog_wdata;
    rdata_reg <= mem[rd_addr];
  end

  always_comb begin
    state_next = state_reg;
    rd_addr    = fetch_ptr_reg;
    case (state_reg)
      IDLE: if (start) state_next = ADDR;
      ADDR: state_next = OPC;
      OPC: begin
        if (is_two_byte(rdata_reg[7:4])) begin
          rd_addr    = fetch_ptr_reg + ADDR_W'(1);
          state_next = OPND;
        end else begin
          state_next = HOLD;
        end
      end
      OPND: state_next = HOLD;
      HOLD: begin
        if (core_ready)
          state_next = (instr_reg[7:4] == OP_HALT) ? IDLE : ADDR;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      fetch_ptr_reg <= '0;
      instr_reg     <= '0;
      operand_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= prog_we && (state_reg != IDLE);
      case (state_reg)
        IDLE: if (start) fetch_ptr_reg <= start_addr;
        OPC: begin
          instr_reg <= rdata_reg;
          if (!is_two_byte(rdata_reg[7:4]))
            operand_reg <= '0;
        end
        OPND: operand_reg <= rdata_reg;
        HOLD: begin
          if (handshake) begin
            if (instr_reg[7:4] == OP_JUMP)
              fetch_ptr_reg <= operand_reg[ADDR_W-1:0];
            else if (is_two_byte(instr_reg[7:4]))
              fetch_ptr_reg <= fetch_ptr_reg + ADDR_W'(2);
            else
              fetch_ptr_reg <= fetch_ptr_reg + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_out   = instr_reg;
  assign operand_out = operand_reg;
  assign instr_valid = (state_reg == HOLD);
  assign fetch_addr  = fetch_ptr_reg;
  assign busy        = (state_reg != IDLE);
  assign prog_err    = err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, hand-written corner
// sequences and a randomized run against a simple program-walk model.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_wdata;
  logic       start;
  logic [7:0] start_addr;
  logic       core_ready;
  logic [7:0] instr_out;
  logic [7:0] operand_out;
  logic       instr_valid;
  logic [7:0] fetch_addr;
  logic       busy;
  logic       prog_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] model_mem [256];

  typedef struct {
    logic [7:0] sa;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] ei;
    logic [7:0] eo;
    int         el;
    logic [7:0] en;
  } vec_t;

  vec_t vecs [8];

  instr_fetch_unit #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .start_addr(start_addr),
    .core_ready(core_ready), .instr_out(instr_out), .operand_out(operand_out),
    .instr_valid(instr_valid), .fetch_addr(fetch_addr), .busy(busy),
    .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    step();
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic do_start(input logic [7:0] a);
    start = 1'b1; start_addr = a;
    step();
    start = 1'b0;
  endtask

  // Latency counts edges from the start/handshake edge (which is edge 1).
  task automatic fetch_one(input string tag, input logic [7:0] ei, input logic [7:0] eo,
                           input int el, input logic [7:0] ea);
    int  lat;
    bit  ok;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      step();
      lat++;
    end
    if (!ok) begin
      check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    end else begin
      $display("[TB] %s: @%02h instr=%02h operand=%02h latency=%0d", tag, fetch_addr,
               instr_out, operand_out, lat);
      check({tag, "_latency"}, lat, el);
      check({tag, "_instr"}, instr_out, ei);
      check({tag, "_operand"}, operand_out, eo);
      check({tag, "_fetch_addr"}, fetch_addr, ea);
    end
  endtask

  task automatic handshake(input string tag, input logic [7:0] en, input logic eb);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    check({tag, "_valid_drop"}, instr_valid, 1'b0);
    check({tag, "_next_addr"}, fetch_addr, en);
    check({tag, "_busy_after"}, busy, eb);
  endtask

  task automatic stall(input string tag, input int n, input logic [7:0] ei, input logic [7:0] eo);
    core_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_stall_valid"}, instr_valid, 1'b1);
      check({tag, "_stall_instr"}, instr_out, ei);
      check({tag, "_stall_operand"}, operand_out, eo);
    end
  endtask

  function automatic bit model_two(input logic [7:0] op);
    return op[7:4] inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
  endfunction

  initial begin
    logic [7:0] ptr, op, opnd, nxt;
    bit         two;
    int         k;

    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; start_addr = '0; core_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    check("rst_valid", instr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", prog_err, 1'b0);
    check("rst_fetch_addr", fetch_addr, 8'h00);
    check("rst_instr", instr_out, 8'h00);
    check("rst_operand", operand_out, 8'h00);

    // {start, byte0, byte1, instr, operand, latency, next fetch_addr}
    vecs[0] = '{8'h10, 8'h13, 8'h05, 8'h13, 8'h05, 4, 8'h12};
    vecs[1] = '{8'h30, 8'h20, 8'hAA, 8'h20, 8'h00, 3, 8'h31};
    vecs[2] = '{8'h00, 8'h70, 8'h40, 8'h70, 8'h40, 4, 8'h40};
    vecs[3] = '{8'hFF, 8'h31, 8'h07, 8'h31, 8'h07, 4, 8'h01};
    vecs[4] = '{8'h60, 8'h45, 8'h12, 8'h45, 8'h12, 4, 8'h62};
    vecs[5] = '{8'h70, 8'h89, 8'h33, 8'h89, 8'h00, 3, 8'h71};
    vecs[6] = '{8'h80, 8'h0C, 8'h99, 8'h0C, 8'h00, 3, 8'h81};
    vecs[7] = '{8'hFE, 8'h55, 8'h66, 8'h55, 8'h66, 4, 8'h00};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      write_byte(vecs[i].sa, vecs[i].b0);
      write_byte(vecs[i].sa + 8'd1, vecs[i].b1);
      do_start(vecs[i].sa);
      fetch_one($sformatf("vec%0d", i), vecs[i].ei, vecs[i].eo, vecs[i].el, vecs[i].sa);
      handshake($sformatf("vec%0d", i), vecs[i].en, 1'b1);
    end

    // Back-to-back with core_ready held high: presentations at cycles 4 and 7.
    do_reset();
    write_byte(8'h10, 8'h13); write_byte(8'h11, 8'h05); write_byte(8'h12, 8'h20);
    core_ready = 1'b1;
    do_start(8'h10);
    fetch_one("seq_first", 8'h13, 8'h05, 4, 8'h10);
    handshake("seq_first", 8'h12, 1'b1);
    core_ready = 1'b1;
    fetch_one("seq_second", 8'h20, 8'h00, 3, 8'h12);
    handshake("seq_second", 8'h13, 1'b1);

    // Backpressure for 5 cycles, then exactly one handshake.
    do_reset();
    do_start(8'h10);
    fetch_one("bp", 8'h13, 8'h05, 4, 8'h10);
    stall("bp", 5, 8'h13, 8'h05);
    check("bp_hold_addr", fetch_addr, 8'h10);
    handshake("bp", 8'h12, 1'b1);
    fetch_one("bp_next", 8'h20, 8'h00, 3, 8'h12);

    // HALT returns to idle and stays quiet.
    do_reset();
    write_byte(8'h20, 8'hF0);
    do_start(8'h20);
    fetch_one("halt", 8'hF0, 8'h00, 3, 8'h20);
    handshake("halt", 8'h21, 1'b0);
    core_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("halt_quiet_valid", instr_valid, 1'b0);
      check("halt_quiet_busy", busy, 1'b0);
    end
    core_ready = 1'b0;

    // Host write while busy is dropped and flagged for one cycle.
    do_reset();
    write_byte(8'h40, 8'h21);
    do_start(8'h40);
    fetch_one("perr", 8'h21, 8'h00, 3, 8'h40);
    prog_we = 1'b1; prog_addr = 8'h40; prog_wdata = 8'hFF;
    step();
    prog_we = 1'b0;
    check("perr_pulse", prog_err, 1'b1);
    check("perr_still_valid", instr_valid, 1'b1);
    step();
    check("perr_one_cycle", prog_err, 1'b0);
    do_reset();
    do_start(8'h40);
    fetch_one("perr_refetch", 8'h21, 8'h00, 3, 8'h40);

    // Reset while the operand byte is being fetched.
    do_reset();
    write_byte(8'h50, 8'h35); write_byte(8'h51, 8'h77);
    core_ready = 1'b1;
    do_start(8'h50);
    step(); step();
    check("opnd_busy_before", busy, 1'b1);
    do_reset();
    check("opnd_rst_valid", instr_valid, 1'b0);
    check("opnd_rst_busy", busy, 1'b0);
    check("opnd_rst_addr", fetch_addr, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("opnd_rst_quiet", instr_valid, 1'b0);
    end
    core_ready = 1'b0;

    // Randomized programs against the program-walk model.
    for (int prog = 0; prog < 3; prog++) begin
      do_reset();
      for (int a = 0; a < 256; a++)
        write_byte(8'(a), 8'($urandom_range(0, 255)));
      ptr = 8'($urandom_range(0, 255));
      do_start(ptr);
      for (int n = 0; n < 60; n++) begin
        op   = model_mem[ptr];
        two  = model_two(op);
        opnd = two ? model_mem[8'(ptr + 8'd1)] : 8'h00;
        if (op[7:4] == 4'h7)
          nxt = opnd;
        else
          nxt = 8'(ptr + (two ? 8'd2 : 8'd1));
        fetch_one("rand", op, opnd, two ? 4 : 3, ptr);
        k = $urandom_range(0, 3);
        stall("rand", k, op, opnd);
        handshake("rand", nxt, op[7:4] != 4'hF);
        if (op[7:4] == 4'hF) begin
          ptr = 8'($urandom_range(0, 255));
          do_start(ptr);
        end else begin
          ptr = nxt;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
